hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage pipeline: tracks E/M/W producers and derives stall and forward selects.
// Optional macro HAZARD_STALL_CNT_EN adds a saturating 16-bit stall counter output (stall_cnt).
module hazard_scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wreg,
    input  logic [1:0] d_tnew,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic [1:0] fwd_m_rt
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [4:0] e_wreg, e_rs, e_rt, m_wreg, m_rt, w_wreg;
    logic [1:0] e_tnew, m_tnew, w_tnew;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A source needs to wait if any matching in-flight producer is still further from done than the use point.
    function automatic logic src_hazard(
        input logic [4:0] r,  input logic [1:0] tuse,
        input logic [4:0] ew, input logic [1:0] et,
        input logic [4:0] mw, input logic [1:0] mt,
        input logic [4:0] ww, input logic [1:0] wt
    );
        if (tuse == TUSE_NONE || r == 5'd0)
            return 1'b0;
        return (ew == r && et > tuse) || (mw == r && mt > tuse) || (ww == r && wt > tuse);
    endfunction

    // Youngest match wins; a match whose result is not ready yet blocks older stages.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] r,
        input logic [4:0] ew, input logic [1:0] et,
        input logic [4:0] mw, input logic [1:0] mt,
        input logic [4:0] ww, input logic [1:0] wt
    );
        if (r == 5'd0)
            return 2'b00;
        if (ew == r)
            return (et == 2'd0) ? 2'b01 : 2'b00;
        if (mw == r)
            return (mt == 2'd0) ? 2'b10 : 2'b00;
        if (ww == r)
            return (wt == 2'd0) ? 2'b11 : 2'b00;
        return 2'b00;
    endfunction

    always_comb begin
        stall = d_valid &&
                (src_hazard(d_rs, d_tuse_rs, e_wreg, e_tnew, m_wreg, m_tnew, w_wreg, w_tnew) ||
                 src_hazard(d_rt, d_tuse_rt, e_wreg, e_tnew, m_wreg, m_tnew, w_wreg, w_tnew));
    end

    always_comb begin
        fwd_d_rs = fwd_pick(d_rs, e_wreg, e_tnew, m_wreg, m_tnew, w_wreg, w_tnew);
        fwd_d_rt = fwd_pick(d_rt, e_wreg, e_tnew, m_wreg, m_tnew, w_wreg, w_tnew);
        fwd_e_rs = fwd_pick(e_rs, 5'd0, 2'd0, m_wreg, m_tnew, w_wreg, w_tnew);
        fwd_e_rt = fwd_pick(e_rt, 5'd0, 2'd0, m_wreg, m_tnew, w_wreg, w_tnew);
        fwd_m_rt = fwd_pick(m_rt, 5'd0, 2'd0, 5'd0, 2'd0, w_wreg, w_tnew);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_wreg <= 5'd0;
            e_tnew <= 2'd0;
            e_rs   <= 5'd0;
            e_rt   <= 5'd0;
            m_wreg <= 5'd0;
            m_tnew <= 2'd0;
            m_rt   <= 5'd0;
            w_wreg <= 5'd0;
            w_tnew <= 2'd0;
        end else begin
            if (stall) begin
                e_wreg <= 5'd0;
                e_tnew <= 2'd0;
                e_rs   <= 5'd0;
                e_rt   <= 5'd0;
            end else begin
                e_wreg <= d_valid ? d_wreg : 5'd0;
                e_tnew <= d_tnew;
                e_rs   <= d_rs;
                e_rt   <= d_rt;
            end
            m_wreg <= e_wreg;
            m_tnew <= tnew_dec(e_tnew);
            m_rt   <= e_rt;
            w_wreg <= m_wreg;
            w_tnew <= tnew_dec(m_tnew);
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= 16'd0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
